brick_scan_ctrl: RTL and testbench



---
 rtl/brick_pkg.sv | 10 +
 rtl/brick_scan_ctrl_aabb_overlap.sv | 14 +
 rtl/brick_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_brick_scan_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// brick_pkg: shared state encoding and default geometry for the brick scanner
package brick_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, PADDLE, DONE} state_t;
    localparam int DEF_NUM_COLS        = 5;
    localparam int DEF_NUM_ROWS        = 2;
    localparam int DEF_COL_PITCH       = 128;
    localparam int DEF_ROW_PITCH       = 24;
    localparam int DEF_SCORE_PER_BRICK = 10;
    localparam int SCORE_W             = 16;
endpackage

// File: rtl/brick_scan_ctrl_aabb_overlap.sv
// aabb_overlap: combinational 11-bit axis-aligned box overlap test
module aabb_overlap (
    input  logic [10:0] ax,
    input  logic [10:0] ay,
    input  logic [10:0] aw,
    input  logic [10:0] ah,
    input  logic [10:0] bx,
    input  logic [10:0] by,
    input  logic [10:0] bw,
    input  logic [10:0] bh,
    output logic        hit
);
    assign hit = (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
endmodule

// File: rtl/brick_scan_ctrl.sv
// brick_scan_ctrl: per-frame collision sequencer walking all bricks through one shared comparator
// Optional BRICK_TWO_HIT_EN: bricks carry 2-bit health and need two hits to be destroyed.
module brick_scan_ctrl
    import brick_pkg::*;
#(
    parameter int NUM_COLS        = DEF_NUM_COLS,
    parameter int NUM_ROWS        = DEF_NUM_ROWS,
    parameter int COL_PITCH       = DEF_COL_PITCH,
    parameter int ROW_PITCH       = DEF_ROW_PITCH,
    parameter int SCORE_PER_BRICK = DEF_SCORE_PER_BRICK
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    input  logic                         level_load,
    input  logic [9:0]                   ball_x,
    input  logic [9:0]                   ball_y,
    input  logic [9:0]                   ball_w,
    input  logic [9:0]                   ball_h,
    input  logic [9:0]                   paddle_x,
    input  logic [9:0]                   paddle_y,
    input  logic [9:0]                   paddle_w,
    input  logic [9:0]                   paddle_h,
    input  logic [9:0]                   grid_x,
    input  logic [9:0]                   grid_y,
    input  logic [9:0]                   brick_w,
    input  logic [9:0]                   brick_h,
    output logic [NUM_COLS*NUM_ROWS-1:0] alive,
    output logic                         busy,
    output logic                         brick_hit,
    output logic [3:0]                   brick_idx,
    output logic                         paddle_hit,
    output logic                         flip_y,
    output logic [SCORE_W-1:0]           score,
    output logic                         all_cleared
);
    localparam int NUM_BLOCKS = NUM_COLS * NUM_ROWS;

    state_t                  state, state_nx;
    logic [NUM_BLOCKS-1:0]   alive_nx;
    logic [9:0]              sx, sy, sw, sh, px, py, pw, ph, gx, bw_s, bh_s;
    logic [10:0]             bx, by, ox, oy, ow, oh;
    logic [3:0]              col, idx;
    logic                    hit_flag, ov, strike, kill, last_col;
    logic [SCORE_W:0]        score_sum;

    assign last_col  = col == 4'(NUM_COLS - 1);
    assign strike    = state == SCAN && alive[idx] && ov;
    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(SCORE_PER_BRICK);
    assign ox = state == PADDLE ? {1'b0, px} : bx;
    assign oy = state == PADDLE ? {1'b0, py} : by;
    assign ow = state == PADDLE ? {1'b0, pw} : {1'b0, bw_s};
    assign oh = state == PADDLE ? {1'b0, ph} : {1'b0, bh_s};

    aabb_overlap u_ov (
        .ax(ox), .ay(oy), .aw(ow), .ah(oh),
        .bx({1'b0, sx}), .by({1'b0, sy}), .bw({1'b0, sw}), .bh({1'b0, sh}),
        .hit(ov)
    );

`ifdef BRICK_TWO_HIT_EN
    logic [1:0] health [NUM_BLOCKS];

    // health per brick: reloaded on level_load, decremented on every strike
    always_ff @(posedge clk or posedge rst)
        if (rst || level_load) begin
            for (int i = 0; i < NUM_BLOCKS; i++) health[i] <= 2'd2;
        end else if (strike) begin
            health[idx] <= health[idx] - 2'd1;
        end

    assign kill = health[idx] == 2'd1;
`else
    assign kill = 1'b1;
`endif

    // next state and next alive mask; level_load overrides everything
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = frame_tick ? SCAN : IDLE;
            SCAN:    state_nx = (strike || idx == 4'(NUM_BLOCKS - 1)) ? PADDLE : SCAN;
            PADDLE:  state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        alive_nx = alive & ~(NUM_BLOCKS'(strike && kill) << idx);
        if (level_load) begin
            state_nx = IDLE;
            alive_nx = '1;
        end
    end

    // geometry snapshot taken when a scan starts so later input changes are ignored
    always_ff @(posedge clk)
        if (state == IDLE && frame_tick && !level_load)
            {sx, sy, sw, sh, px, py, pw, ph, gx, bw_s, bh_s} <=
                {ball_x, ball_y, ball_w, ball_h, paddle_x, paddle_y, paddle_w, paddle_h, grid_x, brick_w, brick_h};

    // state register, brick position accumulators, score and output pulses
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            alive       <= '1;
            busy        <= 1'b0;
            brick_hit   <= 1'b0;
            brick_idx   <= 4'd0;
            paddle_hit  <= 1'b0;
            flip_y      <= 1'b0;
            score       <= '0;
            all_cleared <= 1'b0;
            hit_flag    <= 1'b0;
            col         <= 4'd0;
            idx         <= 4'd0;
            bx          <= 11'd0;
            by          <= 11'd0;
        end else begin
            state       <= state_nx;
            alive       <= alive_nx;
            all_cleared <= alive_nx == '0;
            busy        <= state_nx != IDLE;
            brick_hit   <= 1'b0;
            paddle_hit  <= 1'b0;
            flip_y      <= 1'b0;
            if (!level_load)
                case (state)
                    IDLE: if (frame_tick) begin
                        col      <= 4'd0;
                        idx      <= 4'd0;
                        hit_flag <= 1'b0;
                        bx       <= {1'b0, grid_x};
                        by       <= {1'b0, grid_y};
                    end
                    SCAN: if (strike) begin
                        brick_hit <= 1'b1;
                        brick_idx <= idx;
                        hit_flag  <= 1'b1;
                        score     <= !kill ? score : score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    end else begin
                        idx <= idx + 4'd1;
                        col <= last_col ? 4'd0 : col + 4'd1;
                        bx  <= last_col ? {1'b0, gx} : bx + 11'(COL_PITCH);
                        by  <= last_col ? by + 11'(ROW_PITCH) : by;
                    end
                    PADDLE: if (ov) begin
                        paddle_hit <= 1'b1;
                        hit_flag   <= 1'b1;
                    end
                    default: flip_y <= hit_flag;
                endcase
        end
endmodule

// File: tb/tb_brick_scan_ctrl.sv
// tb_brick_scan_ctrl: directed self-checking bench for brick_scan_ctrl
module tb_brick_scan_ctrl;
`ifdef BRICK_TWO_HIT_EN
    localparam bit TWO = 1'b1;
`else
    localparam bit TWO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, frame_tick, level_load;
    logic [9:0]  ball_x, ball_y, ball_w, ball_h;
    logic [9:0]  paddle_x, paddle_y, paddle_w, paddle_h;
    logic [9:0]  grid_x, grid_y, brick_w, brick_h;
    logic [9:0]  alive;
    logic        busy, brick_hit, paddle_hit, flip_y, all_cleared;
    logic [3:0]  brick_idx;
    logic [15:0] score;

    int checks = 0, errors = 0;
    int hit_e, hit_idx, ph_e, fy_e, busy_cnt, nhits;
    bit tmo;

    brick_scan_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .level_load(level_load),
        .ball_x(ball_x), .ball_y(ball_y), .ball_w(ball_w), .ball_h(ball_h),
        .paddle_x(paddle_x), .paddle_y(paddle_y), .paddle_w(paddle_w), .paddle_h(paddle_h),
        .grid_x(grid_x), .grid_y(grid_y), .brick_w(brick_w), .brick_h(brick_h),
        .alive(alive), .busy(busy), .brick_hit(brick_hit), .brick_idx(brick_idx),
        .paddle_hit(paddle_hit), .flip_y(flip_y), .score(score), .all_cleared(all_cleared)
    );

    always #5 clk = ~clk;

    task automatic apply_reset;
        rst = 1'b1;
        frame_tick = 1'b0;
        level_load = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_geom(input int bxv, byv, bwv, bhv, pxv, pyv, pwv, phv, bhgt);
        ball_x = 10'(bxv); ball_y = 10'(byv); ball_w = 10'(bwv); ball_h = 10'(bhv);
        paddle_x = 10'(pxv); paddle_y = 10'(pyv); paddle_w = 10'(pwv); paddle_h = 10'(phv);
        grid_x = 10'd0; grid_y = 10'd0; brick_w = 10'd64; brick_h = 10'(bhgt);
    endtask

    // runs one frame, recording the edge index (E0 = tick sample) of each pulse
    task automatic run_frame(input int ll_at, input int tick_at, input bit swap);
        hit_e = -1; hit_idx = -1; ph_e = -1; fy_e = -1; busy_cnt = 0; nhits = 0; tmo = 1'b0;
        @(negedge clk) frame_tick = 1'b1;
        @(posedge clk) #1 frame_tick = 1'b0;
        if (swap) begin ball_x = 10'd10; ball_y = 10'd5; ball_w = 10'd8; ball_h = 10'd8; end
        if (busy) busy_cnt++;
        for (int n = 1; n <= 40 && busy; n++) begin
            level_load = (n == ll_at);
            frame_tick = (n == tick_at);
            @(posedge clk) #1;
            level_load = 1'b0;
            frame_tick = 1'b0;
            if (brick_hit) begin nhits++; hit_e = n; hit_idx = int'(brick_idx); end
            if (paddle_hit) ph_e = n;
            if (flip_y) fy_e = n;
            if (busy) busy_cnt++;
            if (n == 40 && busy) tmo = 1'b1;
        end
        if (tmo) begin errors++; $display("FAIL frame_timeout busy still high after 40 cycles"); end
    endtask

    task automatic test_reset;
        apply_reset();
        checks++; if (alive !== 10'h3FF) begin errors++; $display("FAIL reset_alive got %h want 3ff", alive); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({brick_hit, paddle_hit, flip_y} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {brick_hit, paddle_hit, flip_y}); end
        checks++; if (brick_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", brick_idx); end
        checks++; if (all_cleared !== 1'b0) begin errors++; $display("FAIL reset_cleared got %b want 0", all_cleared); end
    endtask

    task automatic test_single_hit;
        apply_reset();
        set_geom(10, 5, 8, 8, 500, 400, 80, 8, 16);
        run_frame(0, 0, 1'b0);
        checks++; if (hit_e !== 1) begin errors++; $display("FAIL single_hit_edge got %0d want 1", hit_e); end
        checks++; if (hit_idx !== 0) begin errors++; $display("FAIL single_hit_idx got %0d want 0", hit_idx); end
        checks++; if (alive !== (TWO ? 10'h3FF : 10'h3FE)) begin errors++; $display("FAIL single_alive got %h want %h", alive, TWO ? 10'h3FF : 10'h3FE); end
        checks++; if (score !== (TWO ? 16'd0 : 16'd10)) begin errors++; $display("FAIL single_score got %0d want %0d", score, TWO ? 0 : 10); end
        checks++; if (fy_e !== 3) begin errors++; $display("FAIL single_flip_edge got %0d want 3", fy_e); end
        checks++; if (busy_cnt !== 3) begin errors++; $display("FAIL single_busy got %0d want 3", busy_cnt); end
        checks++; if (ph_e !== -1) begin errors++; $display("FAIL single_paddle got %0d want -1", ph_e); end
`ifdef BRICK_TWO_HIT_EN
        run_frame(0, 0, 1'b0);
        checks++; if (hit_e !== 1) begin errors++; $display("FAIL second_hit_edge got %0d want 1", hit_e); end
        checks++; if (alive !== 10'h3FE) begin errors++; $display("FAIL second_alive got %h want 3fe", alive); end
        checks++; if (score !== 16'd10) begin errors++; $display("FAIL second_score got %0d want 10", score); end
        checks++; if (fy_e !== 3) begin errors++; $display("FAIL second_flip got %0d want 3", fy_e); end
`endif
    endtask

    task automatic test_first_hit_only;
        apply_reset();
        set_geom(120, 20, 20, 8, 500, 400, 80, 8, 24);
        run_frame(0, 0, 1'b0);
        checks++; if (nhits !== 1) begin errors++; $display("FAIL first_only_count got %0d want 1", nhits); end
        checks++; if (hit_idx !== 1) begin errors++; $display("FAIL first_only_idx got %0d want 1", hit_idx); end
        checks++; if (hit_e !== 2) begin errors++; $display("FAIL first_only_edge got %0d want 2", hit_e); end
        checks++; if (alive !== (TWO ? 10'h3FF : 10'h3FD)) begin errors++; $display("FAIL first_only_alive got %h want %h", alive, TWO ? 10'h3FF : 10'h3FD); end
        checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL first_only_busy got %0d want 4", busy_cnt); end
        checks++; if (fy_e !== 4) begin errors++; $display("FAIL first_only_flip got %0d want 4", fy_e); end
    endtask

    task automatic test_paddle;
        apply_reset();
        set_geom(300, 300, 8, 8, 280, 304, 40, 8, 16);
        run_frame(0, 0, 1'b0);
        checks++; if (nhits !== 0) begin errors++; $display("FAIL paddle_bricks got %0d want 0", nhits); end
        checks++; if (ph_e !== 11) begin errors++; $display("FAIL paddle_edge got %0d want 11", ph_e); end
        checks++; if (fy_e !== 12) begin errors++; $display("FAIL paddle_flip got %0d want 12", fy_e); end
        checks++; if (busy_cnt !== 12) begin errors++; $display("FAIL paddle_busy got %0d want 12", busy_cnt); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL paddle_score got %0d want 0", score); end
    endtask

    task automatic test_no_wrap;
        apply_reset();
        set_geom(1020, 5, 8, 8, 500, 400, 80, 8, 16);
        run_frame(0, 0, 1'b1);
        checks++; if (nhits !== 0) begin errors++; $display("FAIL nowrap_hits got %0d want 0", nhits); end
        checks++; if (fy_e !== -1) begin errors++; $display("FAIL nowrap_flip got %0d want -1", fy_e); end
        checks++; if (busy_cnt !== 12) begin errors++; $display("FAIL nowrap_busy got %0d want 12", busy_cnt); end
        checks++; if (alive !== 10'h3FF) begin errors++; $display("FAIL nowrap_alive got %h want 3ff", alive); end
    endtask

    task automatic test_level_load;
        apply_reset();
        set_geom(10, 5, 8, 8, 500, 400, 80, 8, 16);
        run_frame(0, 0, 1'b0);
        run_frame(0, 0, 1'b0);
        checks++; if (alive !== (TWO ? 10'h3FE : 10'h3FE)) begin errors++; $display("FAIL ll_pre_alive got %h want 3fe", alive); end
        set_geom(300, 300, 8, 8, 280, 304, 40, 8, 16);
        run_frame(4, 0, 1'b0);
        checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL ll_busy got %0d want 4", busy_cnt); end
        checks++; if ({nhits, ph_e, fy_e} !== {32'd0, -32'sd1, -32'sd1}) begin errors++; $display("FAIL ll_pulses got %0d/%0d/%0d want 0/-1/-1", nhits, ph_e, fy_e); end
        checks++; if (alive !== 10'h3FF) begin errors++; $display("FAIL ll_alive got %h want 3ff", alive); end
        checks++; if (score !== 16'd10) begin errors++; $display("FAIL ll_score got %0d want 10", score); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ll_idle got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        set_geom(300, 300, 8, 8, 500, 400, 80, 8, 16);
        run_frame(0, 3, 1'b0);
        checks++; if (busy_cnt !== 12) begin errors++; $display("FAIL b2b_busy got %0d want 12", busy_cnt); end
        @(posedge clk) #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_queued got %b want 0", busy); end
    endtask

    task automatic test_all_clear;
        int frames;
        apply_reset();
        set_geom(0, 0, 1000, 100, 500, 400, 80, 8, 16);
        frames = TWO ? 20 : 10;
        for (int f = 0; f < frames; f++) begin
            run_frame(0, 0, 1'b0);
            checks++; if (hit_idx !== (TWO ? f / 2 : f)) begin errors++; $display("FAIL clear_idx frame %0d got %0d want %0d", f, hit_idx, TWO ? f / 2 : f); end
            checks++; if (hit_e !== hit_idx + 1) begin errors++; $display("FAIL clear_edge frame %0d got %0d want %0d", f, hit_e, hit_idx + 1); end
        end
        checks++; if (alive !== 10'h000) begin errors++; $display("FAIL clear_alive got %h want 000", alive); end
        checks++; if (all_cleared !== 1'b1) begin errors++; $display("FAIL clear_flag got %b want 1", all_cleared); end
        checks++; if (score !== 16'd100) begin errors++; $display("FAIL clear_score got %0d want 100", score); end
        run_frame(0, 0, 1'b0);
        checks++; if (nhits !== 0 || busy_cnt !== 12) begin errors++; $display("FAIL clear_empty got hits %0d busy %0d want 0 12", nhits, busy_cnt); end
        @(negedge clk) level_load = 1'b1;
        @(posedge clk) #1 level_load = 1'b0;
        checks++; if ({alive, all_cleared} !== {10'h3FF, 1'b0}) begin errors++; $display("FAIL clear_reload got %h/%b want 3ff/0", alive, all_cleared); end
        checks++; if (score !== 16'd100) begin errors++; $display("FAIL clear_reload_score got %0d want 100", score); end
    endtask

    task automatic test_rst_mid_scan;
        apply_reset();
        set_geom(10, 5, 8, 8, 500, 400, 80, 8, 16);
        run_frame(0, 0, 1'b0);
        @(negedge clk) frame_tick = 1'b1;
        @(posedge clk) #1 frame_tick = 1'b0;
        @(posedge clk) #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if ({alive, score} !== {10'h3FF, 16'd0}) begin errors++; $display("FAIL rst_mid_state got %h/%0d want 3ff/0", alive, score); end
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        set_geom(0, 0, 0, 0, 0, 0, 0, 0, 16);
        test_reset();
        test_single_hit();
        test_first_hit_only();
        test_paddle();
        test_no_wrap();
        test_level_load();
        test_back_to_back();
        test_all_clear();
        test_rst_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
